// File: rtl/gbe_rx_app_ctrl.sv
// Receive-side application controller: converts the gbe_rx FIFO pop interface into a
// ready/valid byte stream with framing, a length limit and overrun recovery.
// Define GBE_RX_APP_CTRL_STATS_EN to build the frame/drop/overrun statistics counters.
module gbe_rx_app_ctrl #(
  parameter int MAX_LEN    = 1500,
  parameter int RST_CYCLES = 4
) (
  input  logic        app_clk,
  input  logic        app_rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_dvld,
  input  logic        rx_eof,
  input  logic        rx_badframe,
  input  logic [31:0] rx_srcip,
  input  logic [15:0] rx_srcport,
  input  logic        rx_overrun,
  output logic        rx_ack,
  output logic        rx_rst,
  output logic [7:0]  usr_data,
  output logic        usr_valid,
  input  logic        usr_ready,
  output logic        usr_sof,
  output logic        usr_eof,
  output logic        usr_err,
  output logic [31:0] usr_srcip,
  output logic [15:0] usr_srcport,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt,
  output logic [15:0] ovr_cnt
);

  typedef enum logic [2:0] {
    S_PASS,
    S_DROP,
    S_ABORT,
    S_RESET,
    S_WAIT
  } state_t;

  localparam logic [10:0] LEN_LAST = 11'(MAX_LEN - 1);
  localparam logic [3:0]  RST_LOAD = 4'(RST_CYCLES - 1);

  state_t      state, state_nxt;
  logic        first, first_nxt;
  logic [10:0] len, len_nxt;
  logic [3:0]  rst_cnt, rst_cnt_nxt;
  logic        trunc;

  // Source identification is a pure pass-through and is valid with every beat.
  assign usr_srcip   = rx_srcip;
  assign usr_srcport = rx_srcport;

  // This byte would exceed the length limit without being the frame's natural end.
  assign trunc = (len == LEN_LAST) && !rx_eof;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge app_clk) begin
    if (app_rst) begin
      state   <= S_RESET;
      first   <= 1'b1;
      len     <= '0;
      rst_cnt <= RST_LOAD;
    end else begin
      state   <= state_nxt;
      first   <= first_nxt;
      len     <= len_nxt;
      rst_cnt <= rst_cnt_nxt;
    end
  end

  // NOTE: every output and next-state value gets a default before the case so no
  // path through the block can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    first_nxt   = first;
    len_nxt     = len;
    rst_cnt_nxt = rst_cnt;
    rx_ack      = 1'b0;
    rx_rst      = 1'b0;
    usr_valid   = 1'b0;
    usr_data    = 8'h00;
    usr_sof     = first;
    usr_eof     = 1'b0;
    usr_err     = 1'b0;

    case (state)
      S_PASS: begin
        if (rx_overrun) begin
          // A partially delivered frame must be closed with a synthetic error beat.
          if (first) begin
            state_nxt   = S_RESET;
            rst_cnt_nxt = RST_LOAD;
          end else begin
            state_nxt = S_ABORT;
          end
        end else begin
          usr_valid = rx_dvld;
          usr_data  = rx_data;
          usr_eof   = rx_eof || trunc;
          usr_err   = (rx_eof && rx_badframe) || trunc;
          rx_ack    = rx_dvld && usr_ready;
          if (rx_ack) begin
            if (rx_eof) begin
              first_nxt = 1'b1;
              len_nxt   = '0;
            end else if (trunc) begin
              state_nxt = S_DROP;
              first_nxt = 1'b1;
              len_nxt   = '0;
            end else begin
              first_nxt = 1'b0;
              len_nxt   = len + 11'd1;
            end
          end
        end
      end

      S_DROP: begin
        if (rx_overrun) begin
          state_nxt   = S_RESET;
          rst_cnt_nxt = RST_LOAD;
        end else begin
          rx_ack = rx_dvld;
          if (rx_dvld && rx_eof) begin
            state_nxt = S_PASS;
            first_nxt = 1'b1;
            len_nxt   = '0;
          end
        end
      end

      S_ABORT: begin
        usr_valid = 1'b1;
        usr_eof   = 1'b1;
        usr_err   = 1'b1;
        if (usr_ready) begin
          state_nxt   = S_RESET;
          rst_cnt_nxt = RST_LOAD;
          first_nxt   = 1'b1;
          len_nxt     = '0;
        end
      end

      S_RESET: begin
        rx_rst = 1'b1;
        if (rst_cnt == 4'd0) begin
          state_nxt = S_WAIT;
        end else begin
          rst_cnt_nxt = rst_cnt - 4'd1;
        end
      end

      S_WAIT: begin
        if (!rx_overrun) begin
          state_nxt = S_PASS;
          first_nxt = 1'b1;
          len_nxt   = '0;
        end
      end

      default: begin
        state_nxt   = S_RESET;
        rst_cnt_nxt = RST_LOAD;
      end
    endcase

    // Reset is synchronous, so the outputs must be silenced combinationally while it is held.
    if (app_rst) begin
      rx_ack    = 1'b0;
      rx_rst    = 1'b1;
      usr_valid = 1'b0;
      usr_data  = 8'h00;
      usr_sof   = 1'b1;
      usr_eof   = 1'b0;
      usr_err   = 1'b0;
    end
  end

`ifdef GBE_RX_APP_CTRL_STATS_EN
  logic        beat_end;
  logic [15:0] frame_q, drop_q, ovr_q;

  // Every frame closes with exactly one accepted eof beat; usr_err sorts good from dropped.
  assign beat_end = usr_valid && usr_ready && usr_eof;

  always_ff @(posedge app_clk) begin
    if (app_rst) begin
      frame_q <= '0;
      drop_q  <= '0;
      ovr_q   <= '0;
    end else begin
      if (beat_end && !usr_err) frame_q <= frame_q + 16'd1;
      if (beat_end && usr_err)  drop_q  <= drop_q + 16'd1;
      if (state_nxt == S_RESET && state != S_RESET) ovr_q <= ovr_q + 16'd1;
    end
  end

  assign frame_cnt = frame_q;
  assign drop_cnt  = drop_q;
  assign ovr_cnt   = ovr_q;
`else
  assign frame_cnt = '0;
  assign drop_cnt  = '0;
  assign ovr_cnt   = '0;
`endif

endmodule

// File: tb/tb_gbe_rx_app_ctrl.sv
// Bench for gbe_rx_app_ctrl: a queue-based FIFO model feeds the DUT and a frame-level
// reference model predicts every delivered beat and the statistics counters.
module tb_gbe_rx_app_ctrl;

  localparam int MAX_LEN    = 16;
  localparam int RST_CYCLES = 4;

  logic        app_clk = 1'b0;
  logic        app_rst;
  logic [7:0]  rx_data;
  logic        rx_dvld;
  logic        rx_eof;
  logic        rx_badframe;
  logic [31:0] rx_srcip;
  logic [15:0] rx_srcport;
  logic        rx_overrun;
  logic        rx_ack;
  logic        rx_rst;
  logic [7:0]  usr_data;
  logic        usr_valid;
  logic        usr_ready;
  logic        usr_sof;
  logic        usr_eof;
  logic        usr_err;
  logic [31:0] usr_srcip;
  logic [15:0] usr_srcport;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;
  logic [15:0] ovr_cnt;

  gbe_rx_app_ctrl #(.MAX_LEN(MAX_LEN), .RST_CYCLES(RST_CYCLES)) dut (
    .app_clk(app_clk), .app_rst(app_rst),
    .rx_data(rx_data), .rx_dvld(rx_dvld), .rx_eof(rx_eof), .rx_badframe(rx_badframe),
    .rx_srcip(rx_srcip), .rx_srcport(rx_srcport), .rx_overrun(rx_overrun),
    .rx_ack(rx_ack), .rx_rst(rx_rst),
    .usr_data(usr_data), .usr_valid(usr_valid), .usr_ready(usr_ready),
    .usr_sof(usr_sof), .usr_eof(usr_eof), .usr_err(usr_err),
    .usr_srcip(usr_srcip), .usr_srcport(usr_srcport),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .ovr_cnt(ovr_cnt)
  );

  always #5 app_clk = ~app_clk;

  typedef struct packed {
    logic [7:0]  data;
    logic        eof;
    logic        bad;
    logic [31:0] ip;
    logic [15:0] port;
  } fifo_byte_t;

  typedef struct packed {
    logic [7:0]  data;
    logic        sof;
    logic        eof;
    logic        err;
    logic        any_src;
    logic [31:0] ip;
    logic [15:0] port;
  } beat_t;

  fifo_byte_t  fifo[$];
  beat_t       exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_frame = '0;
  logic [15:0] exp_drop  = '0;
  logic [15:0] exp_ovr   = '0;
  int          ready_mode = 0;
  int          avail_pct  = 100;
  bit          tog = 1'b0;
  bit          strict_ack = 1'b0;
  int          n_beats = 0;
  int          rst_seen = 0;

  // Counters read as zero when the statistics option is not built.
  function automatic logic [15:0] stat(input logic [15:0] v);
`ifdef GBE_RX_APP_CTRL_STATS_EN
    return v;
`else
    return v & 16'h0000;
`endif
  endfunction

  // One clock cycle: drive from the FIFO model at the falling edge, observe, then pop/flush.
  task automatic step();
    beat_t e;
    logic  ack, rst;
    case (ready_mode)
      0:       usr_ready = 1'b1;
      1:       begin tog = !tog; usr_ready = tog; end
      default: usr_ready = ($urandom_range(0, 99) < 75);
    endcase
    if (fifo.size() != 0 && $urandom_range(0, 99) < avail_pct) begin
      rx_dvld     = 1'b1;
      rx_data     = fifo[0].data;
      rx_eof      = fifo[0].eof;
      rx_badframe = fifo[0].bad;
      rx_srcip    = fifo[0].ip;
      rx_srcport  = fifo[0].port;
    end else begin
      rx_dvld     = 1'b0;
      rx_data     = 8'($urandom);
      rx_eof      = 1'b0;
      rx_badframe = 1'b0;
      rx_srcip    = $urandom;
      rx_srcport  = 16'($urandom);
    end
    #1;
    if (strict_ack) begin
      n_cmp++;
      if (rx_ack !== (usr_ready && rx_dvld)) begin
        n_err++;
        $display("FAIL ack_gating: rx_ack=%b with usr_ready=%b rx_dvld=%b", rx_ack, usr_ready, rx_dvld);
      end
    end
    if (usr_valid === 1'b1 && usr_ready) begin
      n_beats++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_beat: got data=%h sof=%b eof=%b err=%b, required no beat",
                 usr_data, usr_sof, usr_eof, usr_err);
      end else begin
        e = exp_q.pop_front();
        if (usr_data !== e.data || usr_sof !== e.sof || usr_eof !== e.eof ||
            (usr_err & usr_eof) !== e.err ||
            (!e.any_src && (usr_srcip !== e.ip || usr_srcport !== e.port))) begin
          n_err++;
          $display("FAIL beat: got data=%h sof=%b eof=%b err=%b ip=%h port=%h, required data=%h sof=%b eof=%b err=%b ip=%h port=%h",
                   usr_data, usr_sof, usr_eof, usr_err, usr_srcip, usr_srcport,
                   e.data, e.sof, e.eof, e.err, e.ip, e.port);
        end
      end
    end
    ack = rx_ack;
    rst = rx_rst;
    @(posedge app_clk);
    if (rst === 1'b1) begin
      fifo.delete();
      rst_seen++;
    end else if (ack === 1'b1 && fifo.size() != 0) begin
      void'(fifo.pop_front());
    end
    @(negedge app_clk);
  endtask

  // Queue one frame; keep < 0 applies the full delivery rules, keep >= 0 expects only that many beats.
  task automatic push_frame(input int len, input bit bad, input bit seq, input int keep);
    logic [31:0] ip   = $urandom;
    logic [15:0] port = 16'($urandom);
    int          nexp = (len > MAX_LEN) ? MAX_LEN : len;
    if (keep >= 0) nexp = keep;
    for (int i = 0; i < len; i++) begin
      fifo_byte_t b;
      beat_t      e;
      b.data = seq ? 8'(i) : 8'($urandom);
      b.eof  = (i == len - 1);
      b.bad  = bad && (i == len - 1);
      b.ip   = ip;
      b.port = port;
      fifo.push_back(b);
      if (i < nexp) begin
        e.data    = b.data;
        e.sof     = (i == 0);
        e.eof     = (i == len - 1) || (i == MAX_LEN - 1);
        e.err     = ((i == len - 1) && bad) || (len > MAX_LEN && i == MAX_LEN - 1);
        e.any_src = 1'b0;
        e.ip      = ip;
        e.port    = port;
        exp_q.push_back(e);
      end
    end
    if (keep < 0) begin
      if (len > MAX_LEN || bad) exp_drop++;
      else exp_frame++;
    end
  endtask

  task automatic drain(input string name, input int budget);
    int c = 0;
    while ((fifo.size() != 0 || exp_q.size() != 0) && c < budget) begin
      step();
      c++;
    end
    n_cmp++;
    if (fifo.size() != 0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_timeout: fifo=%0d beats_left=%0d after %0d cycles, required 0 and 0",
               name, fifo.size(), exp_q.size(), c);
      fifo.delete();
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    app_rst = 1'b1;
    rx_overrun = 1'b0;
    ready_mode = 0;
    avail_pct = 100;
    step();
    step();
    #1;
    n_cmp++;
    if ({usr_valid, rx_ack, rx_rst, usr_sof, usr_eof, usr_err} !== 6'b001100 || usr_data !== 8'h00) begin
      n_err++;
      $display("FAIL reset_outputs: valid=%b ack=%b rst=%b sof=%b eof=%b err=%b data=%h, required 0 0 1 1 0 0 00",
               usr_valid, rx_ack, rx_rst, usr_sof, usr_eof, usr_err, usr_data);
    end
    n_cmp++;
    if (usr_srcip !== rx_srcip || usr_srcport !== rx_srcport) begin
      n_err++;
      $display("FAIL reset_src_follow: ip=%h port=%h, required %h %h", usr_srcip, usr_srcport, rx_srcip, rx_srcport);
    end
    n_cmp++;
    if ({frame_cnt, drop_cnt, ovr_cnt} !== 48'h0) begin
      n_err++;
      $display("FAIL reset_counters: %h %h %h, required 0 0 0", frame_cnt, drop_cnt, ovr_cnt);
    end
    @(negedge app_clk);
    app_rst = 1'b0;
    rst_seen = 0;
    repeat (RST_CYCLES + 4) step();
    n_cmp++;
    if (rst_seen != RST_CYCLES) begin
      n_err++;
      $display("FAIL reset_rx_rst_len: %0d cycles, required %0d", rst_seen, RST_CYCLES);
    end
  endtask

  task automatic test_good_frame();
    int b0 = n_beats;
    ready_mode = 0;
    push_frame(MAX_LEN, 1'b0, 1'b1, -1);
    drain("good", 200);
    n_cmp++;
    if (n_beats - b0 != MAX_LEN) begin
      n_err++;
      $display("FAIL good_beats: %0d, required %0d", n_beats - b0, MAX_LEN);
    end
    n_cmp++;
    if ({frame_cnt, drop_cnt, ovr_cnt} !== {stat(exp_frame), stat(exp_drop), stat(exp_ovr)}) begin
      n_err++;
      $display("FAIL good_counters: %0d %0d %0d, required %0d %0d %0d", frame_cnt, drop_cnt, ovr_cnt,
               stat(exp_frame), stat(exp_drop), stat(exp_ovr));
    end
  endtask

  task automatic test_backpressure();
    int b0 = n_beats;
    ready_mode = 1;
    strict_ack = 1'b1;
    push_frame(MAX_LEN, 1'b0, 1'b1, -1);
    drain("backpressure", 200);
    strict_ack = 1'b0;
    n_cmp++;
    if (n_beats - b0 != MAX_LEN) begin
      n_err++;
      $display("FAIL backpressure_beats: %0d, required %0d", n_beats - b0, MAX_LEN);
    end
    n_cmp++;
    if ({frame_cnt, drop_cnt, ovr_cnt} !== {stat(exp_frame), stat(exp_drop), stat(exp_ovr)}) begin
      n_err++;
      $display("FAIL backpressure_counters: %0d %0d %0d, required %0d %0d %0d", frame_cnt, drop_cnt, ovr_cnt,
               stat(exp_frame), stat(exp_drop), stat(exp_ovr));
    end
  endtask

  task automatic test_oversize();
    int b0 = n_beats;
    ready_mode = 0;
    push_frame(40, 1'b0, 1'b1, -1);
    push_frame(8, 1'b0, 1'b0, -1);
    drain("oversize", 300);
    n_cmp++;
    if (n_beats - b0 != MAX_LEN + 8) begin
      n_err++;
      $display("FAIL oversize_beats: %0d, required %0d", n_beats - b0, MAX_LEN + 8);
    end
    n_cmp++;
    if ({frame_cnt, drop_cnt, ovr_cnt} !== {stat(exp_frame), stat(exp_drop), stat(exp_ovr)}) begin
      n_err++;
      $display("FAIL oversize_counters: %0d %0d %0d, required %0d %0d %0d", frame_cnt, drop_cnt, ovr_cnt,
               stat(exp_frame), stat(exp_drop), stat(exp_ovr));
    end
  endtask

  task automatic test_bad_frame();
    ready_mode = 2;
    push_frame(12, 1'b1, 1'b1, -1);
    drain("bad", 300);
    n_cmp++;
    if ({frame_cnt, drop_cnt, ovr_cnt} !== {stat(exp_frame), stat(exp_drop), stat(exp_ovr)}) begin
      n_err++;
      $display("FAIL bad_counters: %0d %0d %0d, required %0d %0d %0d", frame_cnt, drop_cnt, ovr_cnt,
               stat(exp_frame), stat(exp_drop), stat(exp_ovr));
    end
  endtask

  task automatic test_overrun();
    int    b0 = n_beats;
    int    c  = 0;
    beat_t ab;
    ready_mode = 0;
    avail_pct = 100;
    push_frame(50, 1'b0, 1'b1, 10);
    while (n_beats - b0 < 10 && c < 200) begin
      step();
      c++;
    end
    n_cmp++;
    if (n_beats - b0 != 10) begin
      n_err++;
      $display("FAIL overrun_prefix: %0d beats, required 10", n_beats - b0);
    end
    rx_overrun = 1'b1;
    ab = '{data: 8'h00, sof: 1'b0, eof: 1'b1, err: 1'b1, any_src: 1'b1, ip: '0, port: '0};
    exp_q.push_back(ab);
    exp_drop++;
    exp_ovr++;
    rst_seen = 0;
    repeat (20) step();
    n_cmp++;
    if (rst_seen != RST_CYCLES) begin
      n_err++;
      $display("FAIL overrun_rx_rst_len: %0d cycles, required %0d", rst_seen, RST_CYCLES);
    end
    n_cmp++;
    if (exp_q.size() != 0 || fifo.size() != 0) begin
      n_err++;
      $display("FAIL overrun_abort: beats_left=%0d fifo=%0d, required 0 and 0", exp_q.size(), fifo.size());
      exp_q.delete();
      fifo.delete();
    end
    rx_overrun = 1'b0;
    push_frame(8, 1'b0, 1'b0, -1);
    drain("overrun_next", 200);
    // Overrun between frames: recovery with no synthetic beat.
    rx_overrun = 1'b1;
    exp_ovr++;
    rst_seen = 0;
    repeat (10) step();
    rx_overrun = 1'b0;
    step();
    n_cmp++;
    if (rst_seen != RST_CYCLES) begin
      n_err++;
      $display("FAIL idle_overrun_rx_rst_len: %0d cycles, required %0d", rst_seen, RST_CYCLES);
    end
    n_cmp++;
    if ({frame_cnt, drop_cnt, ovr_cnt} !== {stat(exp_frame), stat(exp_drop), stat(exp_ovr)}) begin
      n_err++;
      $display("FAIL overrun_counters: %0d %0d %0d, required %0d %0d %0d", frame_cnt, drop_cnt, ovr_cnt,
               stat(exp_frame), stat(exp_drop), stat(exp_ovr));
    end
  endtask

  task automatic test_midframe_reset();
    int b0 = n_beats;
    int c  = 0;
    ready_mode = 0;
    push_frame(12, 1'b0, 1'b1, -1);
    while (n_beats - b0 < 5 && c < 100) begin
      step();
      c++;
    end
    app_rst = 1'b1;
    #1;
    n_cmp++;
    if (usr_valid !== 1'b0 || rx_ack !== 1'b0 || rx_rst !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_outputs: valid=%b ack=%b rst=%b, required 0 0 1", usr_valid, rx_ack, rx_rst);
    end
    step();
    n_cmp++;
    if ({frame_cnt, drop_cnt, ovr_cnt} !== 48'h0) begin
      n_err++;
      $display("FAIL midreset_counters: %0d %0d %0d, required 0 0 0", frame_cnt, drop_cnt, ovr_cnt);
    end
    exp_q.delete();
    exp_frame = '0;
    exp_drop  = '0;
    exp_ovr   = '0;
    app_rst = 1'b0;
    rst_seen = 0;
    repeat (RST_CYCLES + 4) step();
    n_cmp++;
    if (rst_seen != RST_CYCLES) begin
      n_err++;
      $display("FAIL midreset_rx_rst_len: %0d cycles, required %0d", rst_seen, RST_CYCLES);
    end
    push_frame(10, 1'b0, 1'b0, -1);
    drain("midreset_next", 200);
    n_cmp++;
    if ({frame_cnt, drop_cnt, ovr_cnt} !== {stat(exp_frame), stat(exp_drop), stat(exp_ovr)}) begin
      n_err++;
      $display("FAIL midreset_after_counters: %0d %0d %0d, required %0d %0d %0d", frame_cnt, drop_cnt, ovr_cnt,
               stat(exp_frame), stat(exp_drop), stat(exp_ovr));
    end
  endtask

  task automatic test_random();
    ready_mode = 2;
    avail_pct = 80;
    push_frame(1, 1'b0, 1'b0, -1);
    push_frame(MAX_LEN + 1, 1'b0, 1'b0, -1);
    push_frame(MAX_LEN, 1'b1, 1'b0, -1);
    repeat (40) push_frame($urandom_range(1, 40), ($urandom_range(0, 3) == 0), 1'b0, -1);
    drain("random", 20000);
    n_cmp++;
    if ({frame_cnt, drop_cnt, ovr_cnt} !== {stat(exp_frame), stat(exp_drop), stat(exp_ovr)}) begin
      n_err++;
      $display("FAIL random_counters: %0d %0d %0d, required %0d %0d %0d", frame_cnt, drop_cnt, ovr_cnt,
               stat(exp_frame), stat(exp_drop), stat(exp_ovr));
    end
    avail_pct = 100;
  endtask

  initial begin
    app_rst     = 1'b1;
    rx_overrun  = 1'b0;
    usr_ready   = 1'b0;
    rx_dvld     = 1'b0;
    rx_data     = 8'h00;
    rx_eof      = 1'b0;
    rx_badframe = 1'b0;
    rx_srcip    = '0;
    rx_srcport  = '0;
    @(negedge app_clk);
    test_reset();
    test_good_frame();
    test_backpressure();
    test_oversize();
    test_bad_frame();
    test_overrun();
    test_midframe_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
